// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ==========================================================================
// mem_arbiter_if : port C (core), port D (DMA) and RAM signal bundle. Rev 1.0
// ==========================================================================
interface mem_arbiter_if;
  // Port C (cpu core)
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rstrb;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_rdata;
  // Port D (DMA / boot loader)
  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [3:0]  dma_wstrb;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_starve;
  // RAM side
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_rstrb;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_rstrb, cpu_wstrb,
    output cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_wstrb,
    output dma_gnt, dma_rvalid, dma_rdata, dma_starve,
    output m_addr, m_wdata, m_rstrb, m_wstrb,
    input  m_rdata
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_rstrb, cpu_wstrb,
    input  cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_wstrb,
    input  dma_gnt, dma_rvalid, dma_rdata, dma_starve,
    input  m_addr, m_wdata, m_rstrb, m_wstrb,
    output m_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_arbiter : core-priority RAM arbiter with idle-cycle DMA port. Rev 1.0
// Optional MEM_ARB_STATS_EN adds stat_dma_grants / stat_conflicts counters.
// ==========================================================================
module mem_arbiter #(
  parameter int GUARD_CYC    = 1,
  parameter int STARVE_LIMIT = 64,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  arb
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_dma_grants,
  output logic [CNT_W-1:0] stat_conflicts
`endif
);

  localparam int              GW         = (GUARD_CYC > 1) ? $clog2(GUARD_CYC + 1) : 1;
  localparam logic [GW-1:0]   GUARD_LOAD = GW'(GUARD_CYC);
  localparam logic [GW-1:0]   GUARD_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] STARVE_TH = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRD   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic             rvalid_q, rvalid_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic cpu_act;
  logic dma_gnt;
  logic rd_gnt;

  always_comb begin
    cpu_act = arb.cpu_rstrb | (|arb.cpu_wstrb);
    // Reads in GUARD would collide with the core's data still in the RAM output register.
    dma_gnt = arb.dma_req & ~cpu_act & ~((state_q == ST_GUARD) & ~arb.dma_we) & ~rst;
    rd_gnt  = dma_gnt & ~arb.dma_we;
  end

  always_comb begin
    arb.m_addr  = arb.cpu_addr;
    arb.m_wdata = arb.cpu_wdata;
    arb.m_rstrb = 1'b0;
    arb.m_wstrb = 4'h0;
    if (cpu_act) begin
      arb.m_rstrb = arb.cpu_rstrb;
      arb.m_wstrb = arb.cpu_wstrb;
    end else if (dma_gnt) begin
      arb.m_addr  = arb.dma_addr;
      arb.m_wdata = arb.dma_wdata;
      arb.m_rstrb = ~arb.dma_we;
      arb.m_wstrb = arb.dma_we ? arb.dma_wstrb : 4'h0;
    end
  end

  always_comb begin
    state_d  = ST_IDLE;
    guard_d  = '0;
    rvalid_d = rd_gnt;
    if (arb.cpu_rstrb) begin
      if (GUARD_CYC > 0) begin
        state_d = ST_GUARD;
        guard_d = GUARD_LOAD;
      end
    end else if (rd_gnt) begin
      state_d = ST_DRD;
    end else if ((state_q == ST_GUARD) && (guard_q > GUARD_ONE)) begin
      state_d = ST_GUARD;
      guard_d = guard_q - GUARD_ONE;
    end
  end

  always_comb begin
    wait_d = '0;
    if (arb.dma_req && !dma_gnt) begin
      wait_d = (wait_q == CNT_MAX) ? wait_q : wait_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      guard_q  <= '0;
      rvalid_q <= 1'b0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      rvalid_q <= rvalid_d;
      wait_q   <= wait_d;
    end
  end

  always_comb begin
    arb.cpu_rdata  = arb.m_rdata;
    arb.dma_gnt    = dma_gnt;
    // A read granted just before reset is discarded; port D reissues it.
    arb.dma_rvalid = rvalid_q & ~rst;
    arb.dma_rdata  = arb.m_rdata;
    arb.dma_starve = (wait_q >= STARVE_TH);
  end

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] grants_q, grants_d;
  logic [CNT_W-1:0] conflicts_q, conflicts_d;

  always_comb begin
    grants_d    = grants_q;
    conflicts_d = conflicts_q;
    if (dma_gnt && (grants_q != CNT_MAX)) begin
      grants_d = grants_q + CNT_ONE;
    end
    if (cpu_act && arb.dma_req && (conflicts_q != CNT_MAX)) begin
      conflicts_d = conflicts_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q    <= '0;
      conflicts_q <= '0;
    end else begin
      grants_q    <= grants_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign stat_dma_grants = grants_q;
  assign stat_conflicts  = conflicts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_mem_arbiter : directed + random bench for mem_arbiter. Rev 1.0
// ==========================================================================
module tb_mem_arbiter;
  localparam int GUARD_CYC    = 1;
  localparam int STARVE_LIMIT = 64;
  localparam int CNT_W        = 16;
  localparam int CNT_SAT      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if arb ();

`ifdef MEM_ARB_STATS_EN
  logic [CNT_W-1:0] stat_g;
  logic [CNT_W-1:0] stat_c;
`endif

  mem_arbiter #(
    .GUARD_CYC   (GUARD_CYC),
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_dma_grants(stat_g),
    .stat_conflicts (stat_c)
`endif
  );

  // RAM with registered read data, 16 words.
  logic [31:0] ram [16] = '{default: 32'h0};
  logic [31:0] ram_q = 32'h0;
  always @(posedge clk) begin
    if (arb.m_rstrb) ram_q <= ram[arb.m_addr[5:2]];
    for (int b = 0; b < 4; b++)
      if (arb.m_wstrb[b]) ram[arb.m_addr[5:2]][8*b +: 8] <= arb.m_wdata[8*b +: 8];
  end
  assign arb.m_rdata = ram_q;

  // Reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          last_crd = -1000;   // cycle of the latest port-C read
  int          wait_n  = 0;
  bit          exp_rv  = 1'b0;
  logic [31:0] exp_mem [16] = '{default: 32'h0};
  logic [31:0] exp_rdq = 32'h0;
  int          exp_grants = 0;
  int          exp_conf   = 0;
  bit          last_gnt;
  logic        obs_gnt, obs_rv, obs_starve;
  logic [3:0]  obs_wstrb;
  logic [31:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic        cact, guard, gnt, e_rstrb;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;
    bit          rv;
    #4;
    cact  = arb.cpu_rstrb | (|arb.cpu_wstrb);
    guard = ((cyc - last_crd) <= GUARD_CYC);
    gnt   = !rst && arb.dma_req && !cact && !(guard && !arb.dma_we);
    if (cact) begin
      e_addr = arb.cpu_addr; e_wdata = arb.cpu_wdata;
      e_rstrb = arb.cpu_rstrb; e_wstrb = arb.cpu_wstrb;
    end else if (gnt) begin
      e_addr = arb.dma_addr; e_wdata = arb.dma_wdata;
      e_rstrb = !arb.dma_we; e_wstrb = arb.dma_we ? arb.dma_wstrb : 4'h0;
    end else begin
      e_addr = arb.cpu_addr; e_wdata = arb.cpu_wdata;
      e_rstrb = 1'b0; e_wstrb = 4'h0;
    end
    rv = exp_rv && !rst;
    chk("dma_gnt",    32'(arb.dma_gnt),    32'(gnt));
    chk("m_addr",     arb.m_addr,          e_addr);
    chk("m_wdata",    arb.m_wdata,         e_wdata);
    chk("m_rstrb",    32'(arb.m_rstrb),    32'(e_rstrb));
    chk("m_wstrb",    32'(arb.m_wstrb),    32'(e_wstrb));
    chk("cpu_rdata",  arb.cpu_rdata,       exp_rdq);
    chk("dma_rvalid", 32'(arb.dma_rvalid), 32'(rv));
    chk("dma_starve", 32'(arb.dma_starve), 32'(wait_n >= STARVE_LIMIT));
    if (rv) chk("dma_rdata", arb.dma_rdata, exp_rdq);
`ifdef MEM_ARB_STATS_EN
    chk("stat_dma_grants", 32'(stat_g), 32'(exp_grants));
    chk("stat_conflicts",  32'(stat_c), 32'(exp_conf));
`endif
    obs_gnt = arb.dma_gnt; obs_rv = arb.dma_rvalid; obs_starve = arb.dma_starve;
    obs_wstrb = arb.m_wstrb; obs_rdata = arb.dma_rdata;
    last_gnt = gnt;
    @(posedge clk);
    if (e_rstrb) exp_rdq = exp_mem[e_addr[5:2]];
    for (int b = 0; b < 4; b++)
      if (e_wstrb[b]) exp_mem[e_addr[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
    if (rst) begin
      last_crd = -1000; wait_n = 0; exp_rv = 1'b0; exp_grants = 0; exp_conf = 0;
    end else begin
      if (arb.cpu_rstrb) last_crd = cyc;
      exp_rv = gnt && !arb.dma_we;
      wait_n = (arb.dma_req && !gnt) ? ((wait_n < CNT_SAT) ? wait_n + 1 : wait_n) : 0;
      if (gnt && exp_grants < CNT_SAT) exp_grants++;
      if (cact && arb.dma_req && exp_conf < CNT_SAT) exp_conf++;
    end
    cyc++;
    #1;
  endtask

  task automatic cpu_idle();
    arb.cpu_rstrb = 1'b0; arb.cpu_wstrb = 4'h0;
  endtask

  task automatic dma_set(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    arb.dma_req = 1'b1; arb.dma_we = we; arb.dma_addr = a; arb.dma_wdata = d; arb.dma_wstrb = s;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    int r;
    arb.cpu_addr = 32'h0; arb.cpu_wdata = 32'h0; cpu_idle();
    arb.dma_req = 1'b0; arb.dma_we = 1'b0; arb.dma_addr = 32'h0;
    arb.dma_wdata = 32'h0; arb.dma_wstrb = 4'h0;
    @(posedge clk); #1;

    // Reset
    rst = 1'b1; cycle(); cycle();
    rst = 1'b0; cycle();
    chk("reset_rvalid", 32'(obs_rv), 32'd0);
    chk("reset_starve", 32'(obs_starve), 32'd0);

    // CPU-only fetch stream
    for (int i = 0; i < 8; i++) begin
      arb.cpu_addr = $urandom(); arb.cpu_wdata = $urandom(); arb.cpu_rstrb = 1'b1;
      cycle();
    end
    cpu_idle();

    // DMA write with idle core
    dma_set(1'b1, 32'h0000_0040, 32'hDEADBEEF, 4'hF);
    cycle();
    chk("wr_gnt", 32'(obs_gnt), 32'd1);
    chk("wr_wstrb", 32'(obs_wstrb), 32'hF);
    arb.dma_req = 1'b0; cycle();
    chk("wr_no_rvalid", 32'(obs_rv), 32'd0);

    // DMA read blocked by the guard after a core read at cycle N
    dma_set(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    arb.cpu_addr = 32'h0000_0104; arb.cpu_rstrb = 1'b1;
    cycle(); chk("guard_n_gnt", 32'(obs_gnt), 32'd0);
    cpu_idle();
    cycle(); chk("guard_n1_gnt", 32'(obs_gnt), 32'd0);
    cycle(); chk("guard_n2_gnt", 32'(obs_gnt), 32'd1);
    arb.dma_req = 1'b0;
    cycle(); chk("guard_n3_rvalid", 32'(obs_rv), 32'd1);
    chk("guard_n3_rdata", obs_rdata, 32'hDEADBEEF);

    // Starvation under 70 cycles of core writes
    dma_set(1'b1, 32'h0000_0008, 32'h1234_5678, 4'h3);
    for (int k = 0; k < 70; k++) begin
      arb.cpu_addr = $urandom(); arb.cpu_wdata = $urandom(); arb.cpu_wstrb = 4'hF;
      cycle();
      if (k == 63) chk("starve_63", 32'(obs_starve), 32'd0);
      if (k == 64) chk("starve_64", 32'(obs_starve), 32'd1);
    end
    cpu_idle();
    cycle(); chk("starve_gnt", 32'(obs_gnt), 32'd1);
    arb.dma_req = 1'b0;
    cycle(); chk("starve_clear", 32'(obs_starve), 32'd0);

    // Read grant followed by reset
    dma_set(1'b0, 32'h0000_0008, 32'h0, 4'h0);
    cycle(); chk("rst_rd_gnt", 32'(obs_gnt), 32'd1);
    arb.dma_req = 1'b0; rst = 1'b1;
    cycle(); chk("rst_rvalid_drop", 32'(obs_rv), 32'd0);
    rst = 1'b0;
    cycle(); chk("rst_rvalid_after", 32'(obs_rv), 32'd0);
    chk("rst_starve_after", 32'(obs_starve), 32'd0);

`ifdef MEM_ARB_STATS_EN
    rst = 1'b1; cycle(); rst = 1'b0;
    dma_set(1'b1, 32'h0000_000C, 32'hA5A5_A5A5, 4'hF);
    for (int k = 0; k < 3; k++) begin
      arb.cpu_addr = 32'h0000_0010; arb.cpu_rstrb = 1'b1;
      cycle();
    end
    cpu_idle();
    cycle();
    dma_set(1'b1, 32'h0000_0014, 32'h5A5A_5A5A, 4'h1);
    cycle();
    arb.dma_req = 1'b0;
    cycle();
    chk("stat_conflicts_3", 32'(stat_c), 32'd3);
    chk("stat_grants_2", 32'(stat_g), 32'd2);
`endif

    // Randomized traffic
    pend = 1'b0;
    arb.dma_req = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      r = $urandom_range(0, 9);
      arb.cpu_addr = $urandom(); arb.cpu_wdata = $urandom();
      arb.cpu_rstrb = (r >= 5 && r < 8);
      arb.cpu_wstrb = (r >= 8) ? 4'($urandom_range(1, 15)) : 4'h0;
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1'b1;
        dma_set(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      end
      arb.dma_req = pend;
      cycle();
      if (last_gnt) pend = 1'b0;
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
